// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
//   Shared definitions for the configurable serial sequence detector family:
//     - fill_state_e : fill-tracking state (IDLE / FILL / ARMED)
//     - len_width()  : width needed to hold a pattern length 0..max_w
//     - sat_inc()    : saturating increment for counters up to 64 bits wide
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // effective length is zero, detection disabled
        FILL  = 2'd1,   // collecting fresh beats, fill < L
        ARMED = 2'd2    // window is full, fill == L
    } fill_state_e;

    // Bits needed to represent every length from 0 to max_w inclusive.
    function automatic int len_width(input int max_w);
        return $clog2(max_w + 1);
    endfunction

    // Increment val, sticking at the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
        logic [63:0] top;
        top = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (val >= top) ? top : (val + 64'd1);
    endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// -----------------------------------------------------------------------------
// seq_window_cmp
//   Combinational masked compare of a received-bit window against a pattern.
//   Only positions below len take part; among those, positions whose mask bit
//   is 0 are don't-care. A zero length never hits.
//
//   Ports:
//     window  in  MAX_WIDTH  received bits, bit 0 = most recent
//     seq     in  MAX_WIDTH  pattern, right-aligned
//     mask    in  MAX_WIDTH  1 = compare this position, 0 = don't care
//     len     in  LEN_W      effective pattern length (already clamped)
//     hit     out 1          window matches pattern
// -----------------------------------------------------------------------------
module seq_window_cmp
    import seq_detect_pkg::*;
#(
    parameter int MAX_WIDTH = 8
) (
    input  logic [MAX_WIDTH-1:0]              window,
    input  logic [MAX_WIDTH-1:0]              seq,
    input  logic [MAX_WIDTH-1:0]              mask,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]    len,
    output logic                              hit
);

    logic mismatch;

    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if ((i < int'(len)) && mask[i] && (window[i] != seq[i])) begin
                mismatch = 1'b1;
            end
        end
        hit = (len != '0) && !mismatch;
    end

endmodule

// File: rtl/seq_detect_cfg.sv
// -----------------------------------------------------------------------------
// seq_detect_cfg
//   Runtime-programmable serial sequence detector. Bits are shifted in on
//   qualified beats; once L fresh beats have been seen the window is compared
//   (masked) against the programmed pattern and a registered one-cycle match
//   pulse is produced. Overlapping or non-overlapping search is selectable, and
//   a saturating counter tallies matches.
//
//   Ports:
//     clk          in   1          rising-edge clock
//     rst          in   1          synchronous active-high reset (all state)
//     in_valid     in   1          in_bit is a valid beat this cycle
//     in_bit       in   1          serial data, MSB of pattern first
//     cfg_update   in   1          pulse: latch all cfg_* inputs
//     cfg_seq      in   MAX_WIDTH  pattern, right-aligned (bit 0 = last bit)
//     cfg_mask     in   MAX_WIDTH  1 = compare, 0 = don't care
//     cfg_len      in   LEN_W      pattern length (values > MAX_WIDTH clamp)
//     cfg_overlap  in   1          1 = overlapping, 0 = non-overlapping
//     clr_cnt      in   1          synchronous clear of match_cnt
//     match        out  1          registered one-cycle match pulse
//     match_cnt    out  CNT_WIDTH  saturating match count
//     armed        out  1          window full, a match is possible next beat
// -----------------------------------------------------------------------------
module seq_detect_cfg
    import seq_detect_pkg::*;
#(
    parameter int                  MAX_WIDTH   = 8,
    parameter int                  DEF_LEN     = 5,
    parameter logic [MAX_WIDTH-1:0] DEF_SEQ    = 8'b0001_0010,
    parameter bit                  DEF_OVERLAP = 1'b1,
    parameter int                  CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic                              in_bit,
    input  logic                              cfg_update,
    input  logic [MAX_WIDTH-1:0]              cfg_seq,
    input  logic [MAX_WIDTH-1:0]              cfg_mask,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]    cfg_len,
    input  logic                              cfg_overlap,
    input  logic                              clr_cnt,
    output logic                              match,
    output logic [CNT_WIDTH-1:0]              match_cnt,
    output logic                              armed
);

    localparam int               LEN_W   = len_width(MAX_WIDTH);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WIDTH);

    // Lengths above MAX_WIDTH behave as MAX_WIDTH.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    logic [MAX_WIDTH-1:0] shift_q,     shift_d;
    logic [LEN_W-1:0]     fill_q,      fill_d;
    fill_state_e          state_q,     state_d;
    logic                 match_q,     match_d;
    logic [CNT_WIDTH-1:0] match_cnt_q, match_cnt_d;
    logic [MAX_WIDTH-1:0] seq_q,       seq_d;
    logic [MAX_WIDTH-1:0] mask_q,      mask_d;
    logic [LEN_W-1:0]     len_q,       len_d;
    logic                 overlap_q,   overlap_d;

    logic [LEN_W-1:0]     len_eff;
    logic [LEN_W-1:0]     fill_inc;
    logic [MAX_WIDTH-1:0] shift_next;
    logic                 beat;
    logic                 hit;

    assign len_eff    = eff_len(len_q);
    // A beat arriving together with cfg_update is dropped.
    assign beat       = in_valid && !cfg_update;
    // Window as it would look after accepting in_bit; the compare looks ahead
    // so the match can be registered on the completing edge.
    assign shift_next = {shift_q[MAX_WIDTH-2:0], in_bit};

    seq_window_cmp #(
        .MAX_WIDTH (MAX_WIDTH)
    ) u_cmp (
        .window (shift_next),
        .seq    (seq_q),
        .mask   (mask_q),
        .len    (len_eff),
        .hit    (hit)
    );

    // ---------------------------------------------------------------------
    // Shift register and configuration next-state
    // ---------------------------------------------------------------------
    always_comb begin
        shift_d   = shift_q;
        seq_d     = seq_q;
        mask_d    = mask_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        if (cfg_update) begin
            seq_d     = cfg_seq;
            mask_d    = cfg_mask;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
        end else if (in_valid) begin
            shift_d = shift_next;
        end
    end

    // ---------------------------------------------------------------------
    // Fill FSM: next state, fill count and match decision
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        fill_inc = fill_q;
        match_d  = 1'b0;

        // Fill after accepting one more beat, saturating at L.
        case (state_q)
            FILL:    fill_inc = fill_q + 1'b1;
            ARMED:   fill_inc = len_eff;
            default: fill_inc = fill_q;
        endcase

        if (cfg_update) begin
            fill_d  = '0;
            state_d = (eff_len(cfg_len) == '0) ? IDLE : FILL;
        end else if (beat && (state_q != IDLE)) begin
            match_d = hit && (fill_inc == len_eff);
            if (match_d && !overlap_q) begin
                // Non-overlapping: the next match needs L fresh beats.
                fill_d  = '0;
                state_d = FILL;
            end else begin
                fill_d  = fill_inc;
                state_d = (fill_inc == len_eff) ? ARMED : FILL;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Match counter
    // ---------------------------------------------------------------------
    always_comb begin
        match_cnt_d = match_cnt_q;
        if (clr_cnt) begin
            // A match landing on the clear still counts.
            match_cnt_d = match_d ? CNT_WIDTH'(1) : '0;
        end else if (match_d) begin
            match_cnt_d = CNT_WIDTH'(sat_inc(64'(match_cnt_q), CNT_WIDTH));
        end
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath / config / counter registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            fill_q      <= '0;
            match_q     <= 1'b0;
            match_cnt_q <= '0;
            seq_q       <= DEF_SEQ;
            mask_q      <= '1;
            len_q       <= LEN_W'(DEF_LEN);
            overlap_q   <= DEF_OVERLAP;
        end else begin
            shift_q     <= shift_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            match_cnt_q <= match_cnt_d;
            seq_q       <= seq_d;
            mask_q      <= mask_d;
            len_q       <= len_d;
            overlap_q   <= overlap_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = match_cnt_q;
    assign armed     = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detect_cfg.sv
module tb_seq_detect_cfg;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_bit, cfg_update, cfg_overlap, clr_cnt;
    logic [7:0]  cfg_seq, cfg_mask;
    logic [3:0]  cfg_len;
    logic        match, armed, match_s, armed_s;
    logic [15:0] match_cnt;
    logic [1:0]  cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_cfg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_update(cfg_update), .cfg_seq(cfg_seq), .cfg_mask(cfg_mask),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
        .match(match), .match_cnt(match_cnt), .armed(armed)
    );

    // Same stimulus, 2-bit counter to exercise saturation.
    seq_detect_cfg #(.CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_update(cfg_update), .cfg_seq(cfg_seq), .cfg_mask(cfg_mask),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
        .match(match_s), .match_cnt(cnt_s), .armed(armed_s)
    );

    // ---------------- reference model ----------------
    // Keeps the history of accepted bits and the number of fresh beats since
    // the last restart; a match is "L fresh beats and the last L bits fit".
    logic [7:0] m_seq = 8'b0001_0010;
    logic [7:0] m_mask = 8'hFF;
    int         m_len = 5;
    bit         m_ovl = 1'b1;
    bit         hist[$];
    int         fresh = 0;
    int         m_cnt = 0;
    int         m_cnt2 = 0;
    bit         m_match = 1'b0;

    function automatic int eff_l();
        return (m_len > 8) ? 8 : m_len;
    endfunction

    function automatic bit window_fits();
        int l = eff_l();
        for (int i = 0; i < l; i++)
            if (m_mask[i] && (hist[hist.size() - 1 - i] != m_seq[i])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        int l;
        if (rst) begin
            m_seq = 8'b0001_0010; m_mask = 8'hFF; m_len = 5; m_ovl = 1'b1;
            hist.delete(); fresh = 0; m_cnt = 0; m_cnt2 = 0; m_match = 1'b0;
            return;
        end
        m_match = 1'b0;
        if (cfg_update) begin
            m_seq = cfg_seq; m_mask = cfg_mask; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            fresh = 0;
        end else if (in_valid) begin
            hist.push_back(in_bit);
            if (hist.size() > 16) void'(hist.pop_front());
            fresh++;
            l = eff_l();
            if (l > 0 && fresh >= l && window_fits()) begin
                m_match = 1'b1;
                if (!m_ovl) fresh = 0;
            end
        end
        if (clr_cnt) begin
            m_cnt  = m_match ? 1 : 0;
            m_cnt2 = m_match ? 1 : 0;
        end else if (m_match) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    function automatic bit m_armed();
        return (eff_l() > 0) && (fresh >= eff_l());
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, model the edge, compare 1 time unit later.
    task automatic step(input logic v, input logic b, input logic cu,
                        input logic [7:0] s, input logic [7:0] mk,
                        input logic [3:0] ln, input logic ov,
                        input logic cl, input logic r);
        in_valid = v; in_bit = b; cfg_update = cu; cfg_seq = s; cfg_mask = mk;
        cfg_len = ln; cfg_overlap = ov; clr_cnt = cl; rst = r;
        @(posedge clk);
        model_edge();
        #1;
        chk("match", match, m_match);
        chk("match_cnt", match_cnt, m_cnt);
        chk("armed", armed, m_armed());
        chk("match_s", match_s, m_match);
        chk("match_cnt_s", cnt_s, m_cnt2);
    endtask

    task automatic beat(input logic b);
        step(1'b1, b, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic b);
        step(1'b0, b, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_rst();
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic cfg(input logic [7:0] s, input logic [7:0] mk,
                       input logic [3:0] ln, input logic ov);
        step(1'b0, 1'b0, 1'b1, s, mk, ln, ov, 1'b0, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v, b, cu;
        logic [7:0] s, mk;
        logic [3:0] ln;
        logic       ov;
        logic       em, ea;
        int         ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t bt(input logic b, input logic em, input logic ea, input int ec);
        vec_t x;
        x.v = 1'b1; x.b = b; x.cu = 1'b0; x.s = 8'h00; x.mk = 8'h00; x.ln = 4'd0;
        x.ov = 1'b0; x.em = em; x.ea = ea; x.ec = ec;
        return x;
    endfunction

    function automatic vec_t cf(input logic [7:0] s, input logic [7:0] mk,
                                input logic [3:0] ln, input logic ov, input int ec);
        vec_t x;
        x.v = 1'b0; x.b = 1'b0; x.cu = 1'b1; x.s = s; x.mk = mk; x.ln = ln;
        x.ov = ov; x.em = 1'b0; x.ea = 1'b0; x.ec = ec;
        return x;
    endfunction

    int         npulse, idx;
    logic [7:0] rs, rm;
    logic [3:0] rl;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_update = 1'b0;
        cfg_seq = '0; cfg_mask = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_cnt = 1'b0;

        // Reset state
        do_rst();
        chk("reset_match", match, 0);
        chk("reset_cnt", match_cnt, 0);
        chk("reset_armed", armed, 0);

        // Defaults 10010 overlapping: matches after beats 5 and 8
        tbl.push_back(bt(1, 0, 0, 0)); tbl.push_back(bt(0, 0, 0, 0));
        tbl.push_back(bt(0, 0, 0, 0)); tbl.push_back(bt(1, 0, 0, 0));
        tbl.push_back(bt(0, 1, 1, 1)); tbl.push_back(bt(0, 0, 1, 1));
        tbl.push_back(bt(1, 0, 1, 1)); tbl.push_back(bt(0, 1, 1, 2));
        // Non-overlap: single match after beat 5, armed drops afterwards
        tbl.push_back(cf(8'b0001_0010, 8'hFF, 4'd5, 1'b0, 2));
        tbl.push_back(bt(1, 0, 0, 2)); tbl.push_back(bt(0, 0, 0, 2));
        tbl.push_back(bt(0, 0, 0, 2)); tbl.push_back(bt(1, 0, 0, 2));
        tbl.push_back(bt(0, 1, 0, 3)); tbl.push_back(bt(0, 0, 0, 3));
        tbl.push_back(bt(1, 0, 0, 3)); tbl.push_back(bt(0, 0, 0, 3));
        // Masked 1001 / mask 1011 / len 4, non-overlap so groups align
        tbl.push_back(cf(8'b0000_1001, 8'b0000_1011, 4'd4, 1'b0, 3));
        tbl.push_back(bt(1, 0, 0, 3)); tbl.push_back(bt(0, 0, 0, 3));
        tbl.push_back(bt(0, 0, 0, 3)); tbl.push_back(bt(1, 1, 0, 4));
        tbl.push_back(bt(1, 0, 0, 4)); tbl.push_back(bt(1, 0, 0, 4));
        tbl.push_back(bt(0, 0, 0, 4)); tbl.push_back(bt(1, 1, 0, 5));
        tbl.push_back(bt(1, 0, 0, 5)); tbl.push_back(bt(0, 0, 0, 5));
        tbl.push_back(bt(1, 0, 0, 5)); tbl.push_back(bt(1, 0, 1, 5));

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].b, tbl[i].cu, tbl[i].s, tbl[i].mk, tbl[i].ln,
                 tbl[i].ov, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_match", i), match, tbl[i].em);
            chk($sformatf("tbl%0d_armed", i), armed, tbl[i].ea);
            chk($sformatf("tbl%0d_cnt", i), match_cnt, tbl[i].ec);
        end

        // in_valid gaps: valid beats 1,0,0,1,0 with differing held bits
        do_rst();
        npulse = 0; idx = -1;
        for (int k = 0; k < 11; k++) begin
            case (k)
                0: beat(1);  1: idle(0); 2: beat(0);  3: idle(1); 4: idle(1);
                5: beat(0);  6: beat(1); 7: idle(0);  8: beat(0); 9: idle(1);
                default: idle(0);
            endcase
            if (match) begin npulse++; idx = k; end
        end
        chk("gap_pulses", npulse, 1);
        chk("gap_pulse_pos", idx, 8);

        // Beat presented with cfg_update is dropped: 5 more beats needed
        step(1'b1, 1'b1, 1'b1, 8'b0001_0010, 8'hFF, 4'd5, 1'b1, 1'b0, 1'b0);
        npulse = 0;
        beat(1); if (match) npulse++;
        beat(0); if (match) npulse++;
        beat(0); if (match) npulse++;
        beat(1); if (match) npulse++;
        chk("drop_early", npulse, 0);
        beat(0);
        chk("drop_match", match, 1);

        // Saturation with len 1, pattern 1
        do_rst();
        cfg(8'h01, 8'hFF, 4'd1, 1'b1);
        for (int k = 0; k < 5; k++) beat(1);
        chk("sat_cnt_s", cnt_s, 3);
        chk("sat_cnt", match_cnt, 5);
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("clr_with_match", match_cnt, 1);
        chk("clr_with_match_s", cnt_s, 1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("clr_alone", match_cnt, 0);

        // rst on completing beat; config returns to defaults
        do_rst();
        beat(1); beat(0); beat(0); beat(1); beat(0);
        cfg(8'h07, 8'hFF, 4'd3, 1'b0);
        beat(1); beat(0); beat(0); beat(1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_match", match, 0);
        chk("rst_cnt", match_cnt, 0);
        beat(1); beat(0); beat(0); beat(1); beat(0);
        chk("rst_default_match", match, 1);

        // len = 0 never matches
        cfg(8'h00, 8'h00, 4'd0, 1'b1);
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            beat(1'($urandom));
            if (match) npulse++;
        end
        chk("len0_pulses", npulse, 0);

        // Randomized run against the model
        do_rst();
        for (int k = 0; k < 3000; k++) begin
            rs = 8'($urandom);
            rm = 8'($urandom) & 8'($urandom);
            rl = ($urandom_range(0, 9) == 9) ? 4'd15 : 4'($urandom_range(0, 6));
            step(($urandom_range(0, 9) < 7), 1'($urandom),
                 ($urandom_range(0, 99) < 2), rs, rm, rl, 1'($urandom),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 999) < 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_cfg.md
Name: seq_detect_cfg

Overview:
- Next-generation serial sequence detector: runtime-programmable pattern (length up to MAX_WIDTH), per-bit don't-care mask, overlap/non-overlap mode, input qualifier and saturating match counter.
- Sits on a 1-bit serial stream (UART/line-code monitors, framing/sync-word search) and replaces fixed-pattern detectors.
- Match output is registered.

Parameters:
- MAX_WIDTH, 8: maximum pattern length in bits; must be >= 2.
- DEF_LEN, 5: pattern length after reset; 1..MAX_WIDTH.
- DEF_SEQ, 8'b0001_0010: pattern after reset, right-aligned. Bit 0 is the last-received bit.
- DEF_OVERLAP, 1: mode after reset. 1 = overlapping, 0 = non-overlapping.
- CNT_WIDTH, 16: match counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is a valid stream beat this cycle.
- in_bit  in  1  serial data, MSB-first with respect to the pattern.
- cfg_update  in  1  one-cycle pulse that latches all cfg_* inputs.
- cfg_seq  in  MAX_WIDTH  pattern, right-aligned.
- cfg_mask  in  MAX_WIDTH  1 = compare bit, 0 = don't care.
- cfg_len  in  $clog2(MAX_WIDTH+1)  pattern length.
- cfg_overlap  in  1  mode select.
- clr_cnt  in  1  synchronous clear of match_cnt.
- match  out  1  one-cycle pulse, registered.
- match_cnt  out  CNT_WIDTH  saturating count of matches.
- armed  out  1  fill count has reached length, so a match is possible on the next beat.

Behaviour:
- Reset: shift_reg=0, fill=0, match=0, match_cnt=0, armed=0. Latched config = DEF_SEQ / all-ones mask / DEF_LEN / DEF_OVERLAP.
- Shift: on in_valid=1, shift_reg <= {shift_reg[MAX_WIDTH-2:0], in_bit}. When in_valid=0, shift_reg, fill and match_cnt all hold.
- Length rules:
  - Effective length L = min(len, MAX_WIDTH).
  - len=0 disables detection: state IDLE, never matches, shifting continues.
- State machine, driven by fill counter (0..L, saturating):
  - IDLE: L=0.
  - FILL: fill<L.
  - ARMED: fill==L, so armed=1.
  - Transitions:
    - FILL->ARMED after L valid beats since reset, cfg_update or (non-overlap) last match.
    - Non-overlap: ARMED->FILL on a match.
    - cfg_update in any state -> fill=0, then FILL, or IDLE if L=0.
- Compare, combinational on next-state window:
  - hit = L!=0 AND, for all i<L with mask[i]=1, next_shift[i]==seq[i].
  - Bits i>=L are ignored. A mask of all zero within L matches every window once full.
- Match:
  - match <= in_valid & hit & (fill_next==L).
  - Asserted in the cycle after the completing beat, i.e. latency 1 cycle from the beat's edge.
  - Overlap=1: fill stays L, so consecutive beats may each match.
  - Overlap=0: fill_next forced to 0 after a match, so the next match needs L fresh beats.
- Counter:
  - match_cnt increments on each match pulse and saturates at all-ones.
  - clr_cnt with a simultaneous new match gives count 1. clr_cnt alone gives 0.
- Config update:
  - Config registers load on cfg_update.
  - An in_valid beat in the same cycle is dropped (not shifted) and cannot match.
  - match_cnt is unaffected.
  - Config inputs are ignored when cfg_update=0.
- rst mid-stream: all state returns to reset values next edge, including config. A match pending that cycle is suppressed.
- rst has priority over cfg_update, which has priority over in_valid.

Decomposition:
- Package seq_detect_pkg:
  - State enum IDLE/FILL/ARMED.
  - Length-width localparam function, e.g. LEN_W = $clog2(MAX_WIDTH+1).
  - Saturating-increment helper.
- Sub-module seq_window_cmp: combinational masked compare of the window against the pattern with length L. Parameter MAX_WIDTH; output hit. Reused by future multi-pattern detectors.
- Shift register, fill FSM, config registers and counter live in the top module.

Test Plan:
- Defaults (10010, overlap), stream 1,0,0,1,0,0,1,0 all valid -> match pulses after beats 5 and 8; match_cnt=2; armed=1 from beat 5 on.
- cfg_update with overlap=0, same seq/len, same 8-beat stream -> single match after beat 5, none after beat 8; armed drops to 0 after the match.
- cfg_update seq=4'b1001, mask=4'b1011, len=4 -> streams 1,0,0,1 and 1,1,0,1 both match; 1,0,1,1 does not.
- in_valid gaps: the 10010 stream with in_valid=0 cycles interleaved (held bits differ) -> exactly one match, 1 cycle after the 5th valid beat; idle cycles never pulse match. A beat sent with cfg_update is dropped, and the match needs 5 more beats.
- CNT_WIDTH=2, overlap=1, seq=1, len=1 -> stream of 5 ones saturates match_cnt at 3. clr_cnt together with a match -> match_cnt=1.
- rst=1 asserted on the completing beat of 10010 -> no match pulse, match_cnt=0, config back to defaults. len=0 -> no match for any 20-bit stream.
